// File: rtl/vblank_write_scheduler.sv
// vblank_write_scheduler
// Buffers CPU sprite-register writes in a small FIFO and releases them to the
// display controller only while the raster is in vertical blank, so register
// updates never land mid-frame. Also produces a vblank-start pulse and a
// free-running frame counter for software frame pacing.
module vblank_write_scheduler #(
    parameter int DEPTH       = 16,
    parameter int CLEAR_INDEX = 127,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_write_i,
    input  logic [6:0]        cpu_index_i,
    input  logic [DATA_W-1:0] cpu_value_i,
    input  logic              in_vblank,
    output logic              disp_write_o,
    output logic [6:0]        disp_index_o,
    output logic [DATA_W-1:0] disp_value_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    output logic              vblank_start_o,
    output logic [15:0]       frame_count_o
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              ENTRY_W  = 7 + DATA_W;
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [6:0]      CLR_IDX  = 7'(CLEAR_INDEX);

    // IDLE: nothing queued; PENDING: queued, waiting for vblank; DRAIN: forwarding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic [AW:0]         count_d;

    logic                clear;
    logic                push;
    logic                reject;
    logic                pop;

    logic                overflow_q;
    logic                vblank_q;
    logic                vblank_start_p1;
    logic [15:0]         frame_cnt_q;

    logic                disp_write_p1;
    logic [6:0]          disp_index_p1;
    logic [DATA_W-1:0]   disp_value_p1;

    // Status flags come straight from the count register (post-edge view)
    assign full_o  = (count == CNT_FULL);
    assign empty_o = (count == '0);

    // Classify the CPU write: overflow clear, accepted push, or dropped push
    always_comb begin
        clear  = cpu_write_i && (cpu_index_i == CLR_IDX);
        push   = cpu_write_i && !clear && !full_o;
        reject = cpu_write_i && !clear && full_o;
    end

    // Next occupancy; a push and a pop in the same cycle cancel out
    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + CNT_ONE;
            2'b01:   count_d = count - CNT_ONE;
            default: count_d = count;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the state stays non-IDLE exactly while entries are queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push) state_d = in_vblank ? DRAIN : PENDING;
            end
            PENDING, DRAIN: begin
                if (count_d == '0)  state_d = IDLE;
                else if (in_vblank) state_d = DRAIN;
                else                state_d = PENDING;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output: forward one entry per cycle whenever something waits and vblank is high
    always_comb begin
        pop = (state_q != IDLE) && in_vblank;
    end

    // FIFO storage; payload only, so it carries no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cpu_index_i, cpu_value_i};
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_d;
            if (clear)       overflow_q <= 1'b0;
            else if (reject) overflow_q <= 1'b1;
        end
    end

    // ---- stage p1: registered display write port, holds last index/value when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_write_p1 <= 1'b0;
            disp_index_p1 <= '0;
            disp_value_p1 <= '0;
        end else begin
            disp_write_p1 <= pop;
            if (pop) {disp_index_p1, disp_value_p1} <= mem[rd_ptr];
        end
    end

    // Vblank edge detection and frame counter (wraps naturally at 16 bits)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q        <= 1'b0;
            vblank_start_p1 <= 1'b0;
            frame_cnt_q     <= '0;
        end else begin
            vblank_q        <= in_vblank;
            vblank_start_p1 <= in_vblank && !vblank_q;
            if (in_vblank && !vblank_q) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign disp_write_o   = disp_write_p1;
    assign disp_index_o   = disp_index_p1;
    assign disp_value_o   = disp_value_p1;
    assign overflow_o     = overflow_q;
    assign vblank_start_o = vblank_start_p1;
    assign frame_count_o  = frame_cnt_q;

endmodule

// File: tb/tb_vblank_write_scheduler.sv
// Self-checking bench for vblank_write_scheduler: a queue-based reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_vblank_write_scheduler;

    localparam int DEPTH = 16;
    localparam int CLR   = 127;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_write_i;
    logic [6:0]  cpu_index_i;
    logic [15:0] cpu_value_i;
    logic        in_vblank;
    logic        disp_write_o;
    logic [6:0]  disp_index_o;
    logic [15:0] disp_value_o;
    logic        full_o;
    logic        empty_o;
    logic        overflow_o;
    logic        vblank_start_o;
    logic [15:0] frame_count_o;

    vblank_write_scheduler #(.DEPTH(DEPTH), .CLEAR_INDEX(CLR)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_write_i    (cpu_write_i),
        .cpu_index_i    (cpu_index_i),
        .cpu_value_i    (cpu_value_i),
        .in_vblank      (in_vblank),
        .disp_write_o   (disp_write_o),
        .disp_index_o   (disp_index_o),
        .disp_value_o   (disp_value_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .overflow_o     (overflow_o),
        .vblank_start_o (vblank_start_o),
        .frame_count_o  (frame_count_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [22:0] mq[$];
    logic        m_ovf;
    logic [15:0] m_frame;
    logic        m_vq;
    logic        m_dw;
    logic [6:0]  m_di;
    logic [15:0] m_dv;
    logic        m_vs;

    logic [22:0] fwd[$];
    int          vs_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0; m_frame = '0; m_vq = 1'b0;
        m_dw = 1'b0; m_di = '0; m_dv = '0; m_vs = 1'b0;
    endtask

    // One clock edge of behaviour, from the inputs seen before the edge
    task automatic model_step();
        logic [22:0] e;
        bit was_full, was_empty;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_dw = 1'b0;
        if (in_vblank && !was_empty) begin
            e = mq.pop_front();
            m_dw = 1'b1;
            m_di = e[22:16];
            m_dv = e[15:0];
        end
        if (cpu_write_i) begin
            if (cpu_index_i == 7'(CLR)) m_ovf = 1'b0;
            else if (was_full)          m_ovf = 1'b1;
            else                        mq.push_back({cpu_index_i, cpu_value_i});
        end
        m_vs = in_vblank && !m_vq;
        if (m_vs) m_frame = m_frame + 16'd1;
        m_vq = in_vblank;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic wr(input logic [6:0] idx, input logic [15:0] val);
        cpu_write_i = 1'b1; cpu_index_i = idx; cpu_value_i = val;
        tick();
        cpu_write_i = 1'b0;
    endtask

    // Per-cycle compare against the model, plus logging of forwarded writes
    always @(negedge clk) begin
        chk("disp_write", disp_write_o, m_dw);
        chk("disp_index", disp_index_o, m_di);
        chk("disp_value", disp_value_o, m_dv);
        chk("full", full_o, mq.size() == DEPTH);
        chk("empty", empty_o, mq.size() == 0);
        chk("overflow", overflow_o, m_ovf);
        chk("vblank_start", vblank_start_o, m_vs);
        chk("frame_count", frame_count_o, m_frame);
        if (disp_write_o) fwd.push_back({disp_index_o, disp_value_o});
        if (vblank_start_o) vs_cnt++;
    end

    initial begin
        logic [22:0] exp_e;
        bit          dead_seen;
        int          run_left;

        reset_n = 1'b0; cpu_write_i = 1'b0; cpu_index_i = '0; cpu_value_i = '0; in_vblank = 1'b0;
        model_reset();
        #12;
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_frame", frame_count_o, 0);
        reset_n = 1'b1;
        tick();

        // queued outside vblank
        fwd.delete();
        wr(7'd2, 16'h0040); wr(7'd3, 16'h0020); wr(7'd5, 16'h0001);
        tick(); tick();
        chk("q_no_fwd", fwd.size(), 0);
        chk("q_model_cnt", mq.size(), 3);
        chk("q_empty", empty_o, 0);
        in_vblank = 1'b1;
        repeat (5) tick();
        in_vblank = 1'b0;
        tick();
        chk("q_fwd_cnt", fwd.size(), 3);
        if (fwd.size() == 3) begin
            chk("q_fwd0", fwd[0], {7'd2, 16'h0040});
            chk("q_fwd1", fwd[1], {7'd3, 16'h0020});
            chk("q_fwd2", fwd[2], {7'd5, 16'h0001});
        end
        chk("q_empty_after", empty_o, 1);

        // overflow
        fwd.delete();
        for (int i = 0; i < 16; i++) wr(7'(10 + i), 16'h1000 + 16'(i));
        chk("ovf_full16", full_o, 1);
        chk("ovf_not_yet", overflow_o, 0);
        wr(7'd40, 16'hDEAD);
        chk("ovf_set", overflow_o, 1);
        wr(7'(CLR), 16'h5555);
        chk("ovf_cleared", overflow_o, 0);
        chk("ovf_full_kept", full_o, 1);
        in_vblank = 1'b1;
        repeat (20) tick();
        in_vblank = 1'b0;
        tick();
        chk("ovf_fwd_cnt", fwd.size(), 16);
        dead_seen = 1'b0;
        foreach (fwd[k]) if (fwd[k][15:0] == 16'hDEAD) dead_seen = 1'b1;
        chk("ovf_dropped_absent", dead_seen, 0);
        if (fwd.size() == 16) chk("ovf_last", fwd[15], {7'd25, 16'h100F});

        // vblank ends mid-drain
        fwd.delete();
        for (int i = 0; i < 16; i++) wr(7'(i), 16'h2000 + 16'(i));
        in_vblank = 1'b1;
        repeat (5) tick();
        in_vblank = 1'b0;
        repeat (3) tick();
        chk("mid_fwd5", fwd.size(), 5);
        chk("mid_cnt11", mq.size(), 11);
        in_vblank = 1'b1;
        repeat (15) tick();
        chk("mid_fwd16", fwd.size(), 16);
        for (int i = 0; i < 16; i++) begin
            exp_e = {7'(i), 16'h2000 + 16'(i)};
            if (i < fwd.size()) chk("mid_order", fwd[i], exp_e);
        end

        // pass-through in vblank
        wr(7'd8, 16'd3);
        tick();
        chk("pt_write", disp_write_o, 1);
        chk("pt_index", disp_index_o, 8);
        chk("pt_value", disp_value_o, 3);
        for (int i = 0; i < 6; i++) begin
            wr(7'd9, 16'(i));
            chk("pt_steady_cnt", mq.size(), 1);
        end
        tick(); tick();

        // reset mid-drain
        in_vblank = 1'b0;
        for (int i = 0; i < 10; i++) wr(7'd30, 16'h3000 + 16'(i));
        in_vblank = 1'b1;
        tick(); tick();
        chk("rmd_write_hi", disp_write_o, 1);
        chk("rmd_cnt8", mq.size(), 8);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rmd_write", disp_write_o, 0);
        chk("rmd_index", disp_index_o, 0);
        chk("rmd_value", disp_value_o, 0);
        chk("rmd_empty", empty_o, 1);
        chk("rmd_full", full_o, 0);
        chk("rmd_frame", frame_count_o, 0);
        chk("rmd_vs", vblank_start_o, 0);
        tick(); tick();
        reset_n = 1'b1;
        fwd.delete();
        vs_cnt = 0;
        repeat (5) tick();
        chk("rmd_no_fwd", fwd.size(), 0);
        chk("rmd_frame1", frame_count_o, 1);

        // frame counter
        vs_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            in_vblank = 1'b0; tick(); tick();
            in_vblank = 1'b1; tick(); tick();
        end
        chk("frm_count4", frame_count_o, 4);
        chk("frm_pulses3", vs_cnt, 3);
        in_vblank = 1'b0;
        tick();
        force dut.frame_cnt_q = 16'hFFFF;
        m_frame = 16'hFFFF;
        #1 release dut.frame_cnt_q;
        tick();
        in_vblank = 1'b1;
        tick();
        chk("frm_wrap", frame_count_o, 0);
        chk("frm_wrap_pulse", vblank_start_o, 1);

        // random traffic
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                in_vblank = ~in_vblank;
                run_left = in_vblank ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 40));
            end
            run_left--;
            cpu_write_i = ($urandom_range(0, 9) < 6);
            cpu_index_i = ($urandom_range(0, 15) == 0) ? 7'(CLR) : 7'($urandom_range(0, 126));
            cpu_value_i = 16'($urandom);
            tick();
        end
        cpu_write_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vblank_write_scheduler.md
# vblank_write_scheduler

Sits between the CPU's peripheral register write port and the display controller's sprite register port. It queues CPU register writes in a small FIFO and forwards them to the display controller only while the raster is in vertical blank, so sprite position, shape and enable updates never tear mid-frame. It also keeps a frame counter and pulses once at the start of each vblank, which software uses for frame pacing.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..64
- CLEAR_INDEX, 127, register index that clears the overflow flag; writes to it are not queued
- clk  in  1  system clock; also clocks the VGA timing generator
- reset_n  in  1  asynchronous, active-low reset
- cpu_write_i  in  1  CPU register write strobe, one cycle per write
- cpu_index_i  in  7  CPU register index
- cpu_value_i  in  16  CPU write data
- in_vblank  in  1  vblank flag from the display controller, synchronous to clk
- disp_write_o  out  1  write strobe to the display controller's register_write_i
- disp_index_o  out  7  to register_index_i
- disp_value_o  out  16  to register_write_value_i
- full_o  out  1  FIFO count == DEPTH
- empty_o  out  1  FIFO count == 0
- overflow_o  out  1  sticky; a write was dropped
- vblank_start_o  out  1  one-cycle pulse on the in_vblank rising edge
- frame_count_o  out  16  number of vblank rising edges since reset

## Operation
- FIFO entry format: {index[6:0], value[15:0]}, 23 bits.
- Count register: log2(DEPTH)+1 bits.
- Pointers: log2(DEPTH) bits and wrap naturally.

**Push**
- Push occurs on cpu_write_i && cpu_index_i != CLEAR_INDEX && !full_o.
- full_o is evaluated from the count before the edge. A push while full is rejected even if a pop occurs in the same cycle.
- A rejected push sets overflow_o. The entry is discarded and nothing else changes.

**Overflow clear**
- cpu_write_i with cpu_index_i == CLEAR_INDEX clears overflow_o at the next edge. The value is ignored and nothing is queued.
- A clear and an overflow cannot occur in the same cycle, because only one CPU write happens per cycle.

**Pop**
- Pop occurs on in_vblank && !empty_o. At most one entry is popped per cycle.
- A simultaneous push and pop leaves the count unchanged.
- An entry pushed into an empty FIFO is not popped in the same cycle it is pushed.

**Output stage**
- Registered.
- On a pop: disp_write_o <= 1, disp_index_o/disp_value_o <= head entry.
- Otherwise disp_write_o <= 0 and index/value hold their last value.

**Vblank tracking**
- vblank_q is the in_vblank value delayed by one cycle.
- vblank_start_o <= in_vblank && !vblank_q.
- On the same edge frame_count_o increments, wrapping 0xFFFF -> 0x0000.

**State machine**
- IDLE (empty): moves to PENDING on a push when !in_vblank, or to DRAIN on a push when in_vblank.
- PENDING (!empty, !in_vblank): moves to DRAIN when in_vblank rises.
- DRAIN (!empty, in_vblank): pops each cycle.
  - Returns to IDLE when the last entry pops and no push occurs in that cycle.
  - Returns to PENDING if in_vblank falls while entries remain.
  - Remaining entries wait for the next vblank; there is no partial-frame drain outside vblank.
- The state is derivable from empty_o and in_vblank. Implementations may encode it either way, as long as the outputs match.

**Reset (asserted at any time, including mid-drain)**
- Pointers, count, overflow_o, vblank_q, frame_count_o, disp_write_o, disp_index_o, disp_value_o and vblank_start_o all go to 0 immediately.
- empty_o = 1, full_o = 0.
- Queued entries are lost.

## Timing
- Latency: a push accepted at edge E, with in_vblank high during cycle E+1, produces disp_write_o high for the cycle after edge E+1. Minimum latency is 2 cycles.
- Throughput: one forwarded write per cycle while in vblank.
- A FIFO of DEPTH entries drains in DEPTH consecutive cycles of disp_write_o high.
- When in_vblank falls at edge F, no pop occurs at F or later. The last disp_write_o pulse is the cycle after edge F-1.
- The cycle after the in_vblank rising edge shows vblank_start_o high and frame_count_o already incremented.
- full_o and empty_o are combinational from the count register and reflect the post-edge count.
- No combinational path from cpu_* to disp_*.

## Test plan
- **Queued outside vblank:** with in_vblank=0, write (2,0x0040), (3,0x0020), (5,1).
  - disp_write_o stays 0; count=3.
  - Raise in_vblank: three consecutive disp_write_o pulses, in order, with exact index/value.
  - empty_o=1 afterwards.
- **Overflow:** with in_vblank=0, push 17 writes with DEPTH=16.
  - full_o=1 after the 16th; overflow_o=1 after the 17th.
  - Drain: exactly 16 writes forwarded, and the 17th value is absent.
  - Write index 127: overflow_o=0, and count is unaffected.
- **Vblank ends mid-drain:** fill 16 entries, then hold in_vblank high for 5 cycles.
  - Exactly 5 writes forwarded; count=11.
  - Next vblank forwards the remaining 11, in order.
- **Pass-through in vblank:** with in_vblank=1, write (8,3).
  - disp_write_o high 2 cycles later with index 8, value 3.
  - Concurrent push/pop at steady state keeps count at 1.
- **Frame counter:** 3 vblank rising edges give frame_count_o=3 and three single-cycle vblank_start_o pulses.
  - Preload to 0xFFFF via a long run (or force) and check wrap to 0.
- **Reset mid-drain:** assert reset_n=0 while disp_write_o=1 with 8 entries queued.
  - All outputs immediately 0, empty_o=1.
  - After release with in_vblank=1, no writes are forwarded.
